serial_add_ctrl: RTL and testbench

Bit-serial add/subtract sequencer that time-shares a single 1-bit adder slice across a multi-bit operation. The slice is a full-adder built from two half-adder cells plus an OR. The block loads two WIDTH-bit operands, feeds one bit pair per cycle LSB-first, registers the carry between cycles, and assembles the result. It sits in the ALU level as the low-area alternative to a parallel ripple adder, driven by a start/done handshake from the control level.

---
 rtl/serial_add_ctrl.sv | 123 ++++++++++++
 tb/tb_serial_add_ctrl.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// serial_add_ctrl : bit-serial add/subtract sequencer sharing one 1-bit adder slice
// Revision: 1.0
// ============================================================================

module half_adder_cell (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic cout
);
  assign sum  = a ^ b;
  assign cout = a & b;
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  localparam int c_cnt_w = $clog2(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_acc;
  logic               r_cy;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_result;
  logic               r_carry;
  logic               r_ovf;

  logic w_s1, w_c1, w_sum, w_c2, w_cout;
  logic w_load, w_last;

  // Full-adder slice: two half-adder cells plus an OR for the carry.
  half_adder_cell u_ha0 (.a(r_a[0]), .b(r_b[0]), .sum(w_s1),  .cout(w_c1));
  half_adder_cell u_ha1 (.a(w_s1),   .b(r_cy),   .sum(w_sum), .cout(w_c2));
  assign w_cout = w_c1 | w_c2;

  assign w_load = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  assign w_last = (r_state == S_RUN) && (r_cnt == c_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_nxt = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (r_cnt == c_last) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = start ? S_RUN : S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Subtraction: invert B and seed the carry with 1 (two's complement).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_cy     <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
      r_carry  <= 1'b0;
      r_ovf    <= 1'b0;
    end else if (w_load) begin
      r_a   <= in0;
      r_b   <= sub ? ~in1 : in1;
      r_cy  <= sub;
      r_cnt <= '0;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_acc <= {w_sum, r_acc[WIDTH-1:1]};
      r_cy  <= w_cout;
      r_cnt <= r_cnt + c_cnt_w'(1);
      // r_cy still holds the carry into the MSB while the last bit is processed.
      if (w_last) begin
        r_result <= {w_sum, r_acc[WIDTH-1:1]};
        r_carry  <= w_cout;
        r_ovf    <= r_cy ^ w_cout;
      end
    end
  end

  assign result   = r_result;
  assign carry    = r_carry;
  assign overflow = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_serial_add_ctrl.sv
`default_nettype none
// ============================================================================
// tb_serial_add_ctrl : directed self-checking bench for serial_add_ctrl (WIDTH=8)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps

module tb_serial_add_ctrl;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             overflow;

  int               n_checks = 0;
  int               n_fail   = 0;
  logic [WIDTH-1:0] prev_res;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(WIDTH)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .sub      (sub),
    .in0      (in0),
    .in1      (in1),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .carry    (carry),
    .overflow (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: {carry, overflow, result} from the operands' sign rules.
  function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                             input logic s);
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] bb;
    logic             ov;
    bb = s ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + (WIDTH+1)'(s);
    if (s) ov = (a[WIDTH-1] != b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    else   ov = (a[WIDTH-1] == b[WIDTH-1]) && (t[WIDTH-1] != a[WIDTH-1]);
    return {t[WIDTH], ov, t[WIDTH-1:0]};
  endfunction

  task automatic run_op(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic s, input logic [WIDTH-1:0] er, input logic ec, input logic eov);
    int lat, nbusy;
    bit both, held;
    @(negedge clk);
    start = 1'b1; in0 = a; in1 = b; sub = s;
    @(posedge clk);
    #1;
    start = 1'b0; in0 = ~a; in1 = ~b; sub = ~s;
    lat = 0; nbusy = 0; both = 1'b0; held = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (busy && done) both = 1'b1;
      if (!done && (result !== prev_res)) held = 1'b0;
      if (done) begin
        lat = c;
        break;
      end
      if (busy) nbusy++;
    end
    check({tag, " latency"}, lat, 9);
    check({tag, " busy_cycles"}, nbusy, 8);
    check({tag, " busy_and_done"}, {31'd0, both}, 0);
    check({tag, " result_held"}, {31'd0, held}, 1);
    check({tag, " result"}, result, er);
    check({tag, " carry"}, carry, ec);
    check({tag, " overflow"}, overflow, eov);
    prev_res = er;
    @(negedge clk);
    check({tag, " done_one_cycle"}, done, 0);
  endtask

  initial begin
    logic [WIDTH+1:0] exp_v;
    logic [WIDTH-1:0] qa [0:2];
    logic [WIDTH-1:0] qb [0:2];
    logic             qs [0:2];
    bit               seen;

    rst = 1'b1; start = 1'b0; sub = 1'b0; in0 = '0; in1 = '0;
    prev_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset flags", {carry, overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    run_op("add_0f_01", 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
    run_op("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_op("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    run_op("sub_5a_00", 8'h5A, 8'h00, 1'b1, 8'h5A, 1'b1, 1'b0);

    // Abort with an asynchronous reset between edges while bit 4 is in flight.
    @(negedge clk);
    start = 1'b1; in0 = 8'h33; in1 = 8'h44; sub = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort result", result, 0);
    check("abort flags", {carry, overflow}, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    prev_res = '0;
    seen = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) seen = 1'b1;
    end
    check("abort no_done", {31'd0, seen}, 0);
    run_op("post_abort_sub", 8'h33, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0);

    // Start held high with operands changing every cycle: accepts only at DONE.
    seen = 1'b0;
    for (int c = 0; c <= 27; c++) begin
      @(negedge clk);
      if (busy && done) seen = 1'b1;
      if (c > 0) begin
        check($sformatf("b2b done c%0d", c), done, ((c % 9) == 0) ? 1 : 0);
        if ((c % 9) == 0) begin
          exp_v = model(qa[c/9-1], qb[c/9-1], qs[c/9-1]);
          check($sformatf("b2b result op%0d", c/9-1), result, exp_v[WIDTH-1:0]);
          check($sformatf("b2b carry op%0d", c/9-1), carry, exp_v[WIDTH+1]);
          check($sformatf("b2b overflow op%0d", c/9-1), overflow, exp_v[WIDTH]);
        end
      end
      if (c < 27) begin
        start = 1'b1;
        in0   = WIDTH'(c * 37 + 11);
        in1   = WIDTH'(c * 53 + 200);
        sub   = ((c % 2) == 1);
        if ((c % 9) == 0) begin
          qa[c/9] = in0;
          qb[c/9] = in1;
          qs[c/9] = sub;
        end
      end else begin
        start = 1'b0;
      end
    end
    check("b2b busy_and_done", {31'd0, seen}, 0);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
